// File: rtl/toggle_event_rx.sv
// ---------------------------------------------------------------------------
// toggle_event_rx
//
// Receiving end of a two-phase toggle handshake. The incoming toggle line is
// synchronised into the clk domain. Every level change, rising or falling,
// becomes one queued event. Queued events are offered to a consumer through a
// valid/ready handshake. Each consumed event inverts ack_toggle so that the
// sender can see its event has been taken.
//
// Parameters
//   SYNC_STAGES : synchroniser depth on toggle_in (2..4)
//   CNT_W       : pending counter width; holds up to 2^CNT_W-1 events
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous active-low reset; release is sampled on clk
//   toggle_in  : two-phase event line; may be asynchronous to clk
//   evt_ready  : consumer accepts the offered event this cycle
//   ovf_clr    : synchronous clear of overflow
//   evt_valid  : at least one event is pending (decode of registered count)
//   pending    : number of events not yet consumed
//   ack_toggle : inverts once per consumed event
//   overflow   : sticky; an event arrived while the counter was full
// ---------------------------------------------------------------------------
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending,
  output logic             ack_toggle,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [CNT_W-1:0]       pending_reg;
  logic [CNT_W-1:0]       pending_next;
  logic                   ack_reg;
  logic                   overflow_reg;
  logic                   overflow_next;

  logic edge_det;
  logic accept;
  logic at_max;
  logic lost_event;

  // Synchroniser chain: sync_reg[0] samples the raw line, and
  // sync_reg[SYNC_STAGES-1] is the first stage that is safe to use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], toggle_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_reg[SYNC_STAGES-1] ^ prev_reg;

  // evt_valid comes only from the registered count. This keeps evt_ready out
  // of any combinational path to evt_valid.
  assign evt_valid  = (pending_reg != '0);
  assign accept     = evt_valid & evt_ready;
  assign at_max     = (pending_reg == CNT_MAX);
  // An event with no accept that finds the counter full is dropped.
  assign lost_event = edge_det & ~accept & at_max;

  always_comb begin
    pending_next = pending_reg;
    if (edge_det && !accept) begin
      if (!at_max) begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (!edge_det && accept) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  // A new overflow in the same cycle as ovf_clr leaves the flag set.
  always_comb begin
    overflow_next = overflow_reg;
    if (lost_event) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg  <= '0;
      ack_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      if (accept) begin
        ack_reg <= ~ack_reg;
      end
    end
  end

  assign pending    = pending_reg;
  assign ack_toggle = ack_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_toggle_event_rx.sv
// ---------------------------------------------------------------------------
// tb_toggle_event_rx
//
// Directed bench for toggle_event_rx with SYNC_STAGES=2 and CNT_W=3.
// Inputs change 1 ns after a rising edge. Outputs are also sampled then.
// ---------------------------------------------------------------------------
module tb_toggle_event_rx;

  logic       clk;
  logic       rst;
  logic       toggle_in;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [2:0] pending;
  logic       ack_toggle;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  toggle_event_rx #(
    .SYNC_STAGES(2),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .toggle_in (toggle_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .pending   (pending),
    .ack_toggle(ack_toggle),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with toggle_in low, released between edges.
  task automatic apply_reset();
    toggle_in = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Flip toggle_in and hold the new level for two cycles.
  task automatic toggle_hold2();
    toggle_in = ~toggle_in;
    tick();
    tick();
  endtask

  task automatic test_reset();
    toggle_in = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    checks++;
    if ({evt_valid, pending, ack_toggle, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b required=000000",
               {evt_valid, pending, ack_toggle, overflow});
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pending !== 3'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: pending=%0d valid=%b required 0/0", pending, evt_valid);
    end
    // When nothing is pending, evt_ready has no effect.
    evt_ready = 1'b1;
    tick();
    tick();
    evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd0 || ack_toggle !== 1'b0) begin
      errors++;
      $display("FAIL empty_ready: pending=%0d ack=%b required 0/0", pending, ack_toggle);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_latency();
    toggle_in = 1'b1;              // stable before edge 1
    tick();                        // edge 1
    tick();                        // edge 2
    checks++;
    if (pending !== 3'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: pending=%0d valid=%b required 0/0", pending, evt_valid);
    end
    tick();                        // edge 3
    checks++;
    if (pending !== 3'd1 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge3: pending=%0d valid=%b required 1/1", pending, evt_valid);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd0 || evt_valid !== 1'b0 || ack_toggle !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: pending=%0d valid=%b ack=%b required 0/0/1",
               pending, evt_valid, ack_toggle);
    end
    $display("test_single_latency done");
  endtask

  task automatic test_burst();
    logic exp_ack;
    apply_reset();
    for (int i = 0; i < 5; i++) toggle_hold2();
    tick();
    tick();
    tick();
    checks++;
    if (pending !== 3'd5) begin
      errors++;
      $display("FAIL burst_fill: pending=%0d required=5", pending);
    end
    exp_ack   = 1'b0;
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_ack = ~exp_ack;
      checks++;
      if (pending !== 3'(4 - k) || ack_toggle !== exp_ack) begin
        errors++;
        $display("FAIL burst_drain[%0d]: pending=%0d ack=%b required %0d/%b",
                 k, pending, ack_toggle, 4 - k, exp_ack);
      end
    end
    tick();
    evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd0 || ack_toggle !== 1'b1 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_final: pending=%0d ack=%b valid=%b required 0/1/0",
               pending, ack_toggle, evt_valid);
    end
    $display("test_burst done");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 7; i++) toggle_hold2();
    tick();
    tick();
    tick();
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: pending=%0d ovf=%b required 7/0", pending, overflow);
    end
    toggle_hold2();                // eighth event
    tick();
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: pending=%0d ovf=%b required 7/1", pending, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: pending=%0d ovf=%b required 7/0", pending, overflow);
    end
    $display("test_overflow done");
  endtask

  // Runs after test_overflow: pending=7, overflow=0, ack=0, toggle_in=0.
  task automatic test_simultaneous();
    toggle_in = ~toggle_in;        // edge_det is high in the third cycle
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b0 || ack_toggle !== 1'b1) begin
      errors++;
      $display("FAIL simul_at_max: pending=%0d ovf=%b ack=%b required 7/0/1",
               pending, overflow, ack_toggle);
    end
    tick();
    checks++;
    if (pending !== 3'd7) begin
      errors++;
      $display("FAIL simul_hold: pending=%0d required=7", pending);
    end
    // A new overflow and ovf_clr in the same cycle: the set takes priority.
    toggle_in = ~toggle_in;
    tick();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || pending !== 3'd7) begin
      errors++;
      $display("FAIL set_over_clr: ovf=%b pending=%0d required 1/7", overflow, pending);
    end
    $display("test_simultaneous done");
  endtask

  // Runs after test_simultaneous: pending=7, overflow=1, ack=1, toggle_in=0.
  task automatic test_reset_mid();
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    evt_ready = 1'b0;
    toggle_in = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (pending !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: pending=%0d ovf=%b required 3/1", pending, overflow);
    end
    #2;
    rst = 1'b0;                    // between edges
    #1;
    checks++;
    if ({evt_valid, pending, ack_toggle, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async_clear: outputs=%b required=000000",
               {evt_valid, pending, ack_toggle, overflow});
    end
    tick();
    #2;
    rst = 1'b1;                    // toggle_in stays at 1
    tick();
    tick();
    tick();
    checks++;
    if (pending !== 3'd1 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_event: pending=%0d valid=%b required 1/1", pending, evt_valid);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pending !== 3'd1 || overflow !== 1'b0 || ack_toggle !== 1'b0) begin
      errors++;
      $display("FAIL mid_single_only: pending=%0d ovf=%b ack=%b required 1/0/0",
               pending, overflow, ack_toggle);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst       = 1'b0;
    toggle_in = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    test_reset();
    test_single_latency();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
